// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared issue-queue sizing constants and popcount helpers
package iq_pkg;
  localparam int IQ_DEPTH  = 16;
  localparam int DISP_W    = 4;
  localparam int AGE       = 5;
  localparam int PRF_WIDTH = 7;
  localparam int IDX_W     = 4;

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + {4'b0, v[i]};
    return s;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + {2'b0, v[i]};
    return s;
  endfunction
endpackage

// File: rtl/iq_free_find.sv
// rtl/iq_free_find.sv - combinational finder of the four lowest set bits of a 16-bit vector
module iq_free_find (
  input  logic [15:0] vec_i,
  output logic [15:0] idx_o,
  output logic [3:0]  vld_o
);
  logic [1:0] c2  [8];
  logic       f2  [8];
  logic [2:0] c4  [4];
  logic [1:0] p4  [4][4];
  logic [4:0] pre [5];

  always_comb begin
    for (int p = 0; p < 8; p++) begin
      c2[p] = {1'b0, vec_i[2*p]} + {1'b0, vec_i[2*p+1]};
      f2[p] = ~vec_i[2*p];
    end
    // Rank k inside a nibble lands in the low pair if k < its count, else the high pair.
    for (int n = 0; n < 4; n++) begin
      c4[n] = {1'b0, c2[2*n]} + {1'b0, c2[2*n+1]};
      for (int k = 0; k < 4; k++) begin
        if (2'(k) < c2[2*n]) begin
          p4[n][k] = {1'b0, (k == 0) ? f2[2*n] : 1'b1};
        end else if ((2'(k) - c2[2*n]) == 2'd0) begin
          p4[n][k] = {1'b1, f2[2*n+1]};
        end else begin
          p4[n][k] = 2'b11;
        end
      end
    end
    pre[0] = '0;
    for (int n = 0; n < 4; n++) pre[n+1] = pre[n] + {2'b0, c4[n]};
    idx_o = '0;
    vld_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 4; n++) begin
        if ((5'(r) >= pre[n]) && (5'(r) < pre[n+1])) begin
          vld_o[r]       = 1'b1;
          idx_o[4*r +: 4] = {2'(n), p4[n][2'(5'(r) - pre[n])]};
        end
      end
    end
  end
endmodule

// File: rtl/iq_alloc_ctrl.sv
// rtl/iq_alloc_ctrl.sv - issue-queue entry allocator: all-or-nothing dispatch grant, free tracking, age stamps
module iq_alloc_ctrl #(
  parameter int IQ_DEPTH = iq_pkg::IQ_DEPTH,
  parameter int DISP_W   = iq_pkg::DISP_W,
  parameter int AGE      = iq_pkg::AGE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DISP_W-1:0]     disp_valid,
  output logic                  disp_ready,
  output logic [DISP_W-1:0]     alloc_v,
  output logic [3:0]            alloc_addr0,
  output logic [3:0]            alloc_addr1,
  output logic [3:0]            alloc_addr2,
  output logic [3:0]            alloc_addr3,
  output logic [AGE-1:0]        alloc_age0,
  output logic [AGE-1:0]        alloc_age1,
  output logic [AGE-1:0]        alloc_age2,
  output logic [AGE-1:0]        alloc_age3,
  input  logic [IQ_DEPTH-1:0]   issue_rel,
  input  logic                  flush,
  output logic [IQ_DEPTH-1:0]   free_vec,
  output logic [4:0]            free_cnt
);
  import iq_pkg::*;

  logic [15:0]      free_q, free_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [AGE-1:0]   age_q, age_d;
  logic [15:0]      rank_idx, grant;
  logic [3:0]       rank_vld;
  logic             legal, fire;
  logic [2:0]       n_req, n_fired;
  logic [IDX_W-1:0] addr  [4];
  logic [AGE-1:0]   age_s [4];

  iq_free_find u_find (
    .vec_i (free_q),
    .idx_o (rank_idx),
    .vld_o (rank_vld)
  );

  always_comb begin
    legal      = disp_valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    n_req      = popcnt4(disp_valid);
    disp_ready = ~rst & ~flush & legal & ({2'b0, n_req} <= cnt_q);
    fire       = disp_ready & (|disp_valid);
    n_fired    = fire ? n_req : 3'd0;
    grant      = '0;
    for (int i = 0; i < 4; i++) begin
      alloc_v[i] = fire & disp_valid[i] & rank_vld[i];
      addr[i]    = alloc_v[i] ? rank_idx[4*i +: 4] : '0;
      age_s[i]   = alloc_v[i] ? age_q + AGE'(i) : '0;
      if (alloc_v[i]) grant[rank_idx[4*i +: 4]] = 1'b1;
    end
    // Releases of already-free entries must not bump the count.
    free_d = (free_q & ~grant) | issue_rel;
    cnt_d  = cnt_q + popcnt16(issue_rel & ~free_q) - {2'b0, n_fired};
    age_d  = age_q + AGE'(n_fired);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      free_q <= 16'hFFFF;
      cnt_q  <= 5'd16;
      age_q  <= '0;
    end else begin
      free_q <= free_d;
      cnt_q  <= cnt_d;
      age_q  <= age_d;
    end
  end

  assign alloc_addr0 = addr[0];
  assign alloc_addr1 = addr[1];
  assign alloc_addr2 = addr[2];
  assign alloc_addr3 = addr[3];
  assign alloc_age0  = age_s[0];
  assign alloc_age1  = age_s[1];
  assign alloc_age2  = age_s[2];
  assign alloc_age3  = age_s[3];
  assign free_vec    = free_q;
  assign free_cnt    = cnt_q;

  a_no_rel_grant_overlap: assert property (@(posedge clk) disable iff (rst) (grant & issue_rel) == 16'h0);
  a_cnt_matches_vec:      assert property (@(posedge clk) disable iff (rst) cnt_q == popcnt16(free_q));
endmodule

// File: tb/tb_iq_alloc_ctrl.sv
// tb/tb_iq_alloc_ctrl.sv - directed scoreboard bench for iq_alloc_ctrl
module tb_iq_alloc_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [3:0]  disp_valid;
  logic [15:0] issue_rel;
  logic        disp_ready;
  logic [3:0]  alloc_v;
  logic [3:0]  alloc_addr0, alloc_addr1, alloc_addr2, alloc_addr3;
  logic [4:0]  alloc_age0, alloc_age1, alloc_age2, alloc_age3;
  logic [15:0] free_vec;
  logic [4:0]  free_cnt;

  logic [31:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  iq_alloc_ctrl dut (
    .clk (clk), .rst (rst), .disp_valid (disp_valid), .disp_ready (disp_ready),
    .alloc_v (alloc_v),
    .alloc_addr0 (alloc_addr0), .alloc_addr1 (alloc_addr1),
    .alloc_addr2 (alloc_addr2), .alloc_addr3 (alloc_addr3),
    .alloc_age0 (alloc_age0), .alloc_age1 (alloc_age1),
    .alloc_age2 (alloc_age2), .alloc_age3 (alloc_age3),
    .issue_rel (issue_rel), .flush (flush),
    .free_vec (free_vec), .free_cnt (free_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [3:0] dv, input logic [15:0] rel);
    rst = r; flush = f; disp_valid = dv; issue_rel = rel;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_alloc(input string tag, input logic rdy, input logic [3:0] v,
                           input logic [15:0] addrs, input logic [19:0] ages);
    push_exp(32'(rdy));
    push_exp(32'(v));
    push_exp(32'(addrs));
    push_exp(32'(ages));
    check({tag, ".ready"}, 32'(disp_ready));
    check({tag, ".alloc_v"}, 32'(alloc_v));
    check({tag, ".addr"}, 32'({alloc_addr3, alloc_addr2, alloc_addr1, alloc_addr0}));
    check({tag, ".age"}, 32'({alloc_age3, alloc_age2, alloc_age1, alloc_age0}));
  endtask

  task automatic chk_state(input string tag, input logic [15:0] fv, input logic [4:0] cnt);
    push_exp(32'(fv));
    push_exp(32'(cnt));
    check({tag, ".free_vec"}, 32'(free_vec));
    check({tag, ".free_cnt"}, 32'(free_cnt));
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'hF, 16'h0);
    chk_alloc("rst_hold", 1'b0, 4'h0, 16'h0, 20'h0);
    @(negedge clk);
    tick();
    drive(1'b0, 1'b0, 4'h0, 16'h0);
    chk_alloc("idle", 1'b1, 4'h0, 16'h0, 20'h0);
    chk_state("after_rst", 16'hFFFF, 5'd16);

    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("first4", 1'b1, 4'hF, {4'd3, 4'd2, 4'd1, 4'd0}, {5'd3, 5'd2, 5'd1, 5'd0});
    tick();
    chk_state("first4_st", 16'hFFF0, 5'd12);

    drive(1'b0, 1'b0, 4'b0101, 16'h0);
    chk_alloc("illegal", 1'b0, 4'h0, 16'h0, 20'h0);
    tick();
    chk_state("illegal_st", 16'hFFF0, 5'd12);

    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("fill_a", 1'b1, 4'hF, {4'd7, 4'd6, 4'd5, 4'd4}, {5'd7, 5'd6, 5'd5, 5'd4});
    tick();
    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("fill_b", 1'b1, 4'hF, {4'd11, 4'd10, 4'd9, 4'd8}, {5'd11, 5'd10, 5'd9, 5'd8});
    tick();
    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("fill_c", 1'b1, 4'hF, {4'd15, 4'd14, 4'd13, 4'd12}, {5'd15, 5'd14, 5'd13, 5'd12});
    tick();
    chk_state("full_st", 16'h0000, 5'd0);
    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("full_req", 1'b0, 4'h0, 16'h0, 20'h0);
    drive(1'b0, 1'b0, 4'h0, 16'h0);
    chk_alloc("full_idle", 1'b1, 4'h0, 16'h0, 20'h0);

    drive(1'b0, 1'b0, 4'h0, 16'h8421);
    tick();
    chk_state("sparse_st", 16'h8421, 5'd4);
    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("sparse", 1'b1, 4'hF, {4'd15, 4'd10, 4'd5, 4'd0}, {5'd19, 5'd18, 5'd17, 5'd16});
    tick();
    drive(1'b0, 1'b0, 4'h1, 16'h0);
    chk_alloc("sparse_full", 1'b0, 4'h0, 16'h0, 20'h0);
    chk_state("sparse_full_st", 16'h0000, 5'd0);

    drive(1'b0, 1'b0, 4'h1, 16'h0010);
    chk_alloc("rel_same_cyc", 1'b0, 4'h0, 16'h0, 20'h0);
    tick();
    drive(1'b0, 1'b0, 4'h1, 16'h0);
    chk_alloc("rel_next_cyc", 1'b1, 4'h1, 16'h0004, 20'd20);
    tick();
    chk_state("rel_next_st", 16'h0000, 5'd0);

    drive(1'b0, 1'b0, 4'h0, 16'hFFFF);
    tick();
    chk_state("rel_all_st", 16'hFFFF, 5'd16);
    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("age_a", 1'b1, 4'hF, {4'd3, 4'd2, 4'd1, 4'd0}, {5'd24, 5'd23, 5'd22, 5'd21});
    tick();
    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("age_b", 1'b1, 4'hF, {4'd7, 4'd6, 4'd5, 4'd4}, {5'd28, 5'd27, 5'd26, 5'd25});
    tick();
    drive(1'b0, 1'b0, 4'h1, 16'h0);
    chk_alloc("age_c", 1'b1, 4'h1, 16'h0008, 20'd29);
    tick();
    chk_state("age_c_st", 16'hFE00, 5'd7);
    drive(1'b0, 1'b0, 4'h7, 16'h0);
    chk_alloc("age_wrap", 1'b1, 4'h7, {4'd0, 4'd11, 4'd10, 4'd9}, {5'd0, 5'd0, 5'd31, 5'd30});
    tick();
    chk_state("age_wrap_st", 16'hF000, 5'd4);
    drive(1'b0, 1'b0, 4'h1, 16'h0);
    chk_alloc("age_after_wrap", 1'b1, 4'h1, 16'h000C, 20'd1);
    tick();
    chk_state("three_free_st", 16'hE000, 5'd3);
    drive(1'b0, 1'b0, 4'hF, 16'h0);
    chk_alloc("short_by_one", 1'b0, 4'h0, 16'h0, 20'h0);
    drive(1'b0, 1'b0, 4'h7, 16'h0);
    chk_alloc("exact_fit", 1'b1, 4'h7, {4'd0, 4'd15, 4'd14, 4'd13}, {5'd0, 5'd4, 5'd3, 5'd2});

    drive(1'b0, 1'b0, 4'h0, 16'h2001);
    tick();
    chk_state("rel_free_st", 16'hE001, 5'd4);

    drive(1'b0, 1'b1, 4'hF, 16'h00FF);
    chk_alloc("flush", 1'b0, 4'h0, 16'h0, 20'h0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 16'h0);
    chk_state("flush_st", 16'hFFFF, 5'd16);
    drive(1'b0, 1'b0, 4'h1, 16'h0);
    chk_alloc("post_flush", 1'b1, 4'h1, 16'h0000, 20'd0);
    tick();
    chk_state("post_flush_st", 16'hFFFE, 5'd15);
    drive(1'b0, 1'b0, 4'b1000, 16'h0);
    chk_alloc("illegal_top", 1'b0, 4'h0, 16'h0, 20'h0);

    drive(1'b1, 1'b0, 4'hF, 16'h00FF);
    chk_alloc("rst_mid", 1'b0, 4'h0, 16'h0, 20'h0);
    tick();
    drive(1'b0, 1'b0, 4'h0, 16'h0);
    chk_state("rst_mid_st", 16'hFFFF, 5'd16);
    drive(1'b0, 1'b0, 4'h3, 16'h0);
    chk_alloc("post_rst", 1'b1, 4'h3, {4'd0, 4'd0, 4'd1, 4'd0}, {5'd0, 5'd0, 5'd1, 5'd0});
    tick();
    chk_state("post_rst_st", 16'hFFFC, 5'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
